ready_skid_slice: RTL and testbench

// - Backward-path register slice for the valid/ready handshake: registers ready_o (and valid_o/data_o) so
//   the downstream ready_i -> upstream ready_o combinational path is broken.
// - 2-entry skid buffer (main + skid); full throughput (1 beat/cycle) with no bubbles; strict in-order.
// - Sits between any two valid/ready stages; complements the forward valid/data slice on long ready paths.

---
 rtl/hs_pkg.sv | 11 +
 rtl/ready_skid_slice.sv | 91 +++++++++
 tb/tb_ready_skid_slice.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hs_pkg.sv
// Shared handshake-slice types. The skid slice tracks whether its main and skid
// registers are occupied.
package hs_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ready_skid_slice.sv
// Backward-path register slice: a two-entry skid buffer whose ready_o comes from a flop,
// cutting the combinational ready_i -> ready_o path while sustaining one beat per cycle.
module ready_skid_slice
  import hs_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i
);

  skid_state_e       state;
  skid_state_e       next_state;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          next_state   = BUSY;
          load_main_in = 1'b1;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (out_fire) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          next_state     = BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // ready_o and valid_o are registered from next_state so neither output sees ready_i combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      ready_o <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      state   <= next_state;
      ready_o <= (next_state != FULL);
      valid_o <= (next_state != EMPTY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o    <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        data_o <= data_i;
      end else if (load_main_skid) begin
        data_o <= skid_data;
      end
      if (load_skid) begin
        skid_data <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_ready_skid_slice.sv
// Self-checking bench for ready_skid_slice: directed scenarios plus randomized traffic,
// all compared against a queue-based model of a two-deep in-order buffer.
module tb_ready_skid_slice;

  localparam int DATA_W     = 8;
  localparam int RAND_BEATS = 10000;
  localparam int RAND_LIMIT = 60000;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_q[$];
  logic              exp_ready;
  logic [DATA_W-1:0] last_data;
  int                beats_in;
  int                beats_out;

  always #5 clk = ~clk;

  ready_skid_slice #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock of traffic; the model is a FIFO of at most two beats whose ready flag lags by one edge.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r);
    logic in_fire;
    logic out_fire;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    #1;
    checkOutput("ready_indep", 32'(ready_o), 32'(exp_ready));
    in_fire  = v & exp_ready;
    out_fire = (model_q.size() != 0) & r;
    @(posedge clk);
    #1;
    if (out_fire) begin
      void'(model_q.pop_front());
      beats_out++;
    end
    if (in_fire) begin
      model_q.push_back(d);
      beats_in++;
    end
    if (model_q.size() != 0) last_data = model_q[0];
    exp_ready = (model_q.size() < 2);
    checkOutput("valid_o", 32'(valid_o), 32'(model_q.size() != 0));
    checkOutput("ready_o", 32'(ready_o), 32'(exp_ready));
    checkOutput("data_o", 32'(data_o), 32'(last_data));
  endtask

  task automatic applyReset();
    valid_i = 1'b0;
    ready_i = 1'b0;
    rst     = 1'b1;
    #1;
    model_q.delete();
    exp_ready = 1'b0;
    last_data = '0;
    checkOutput("rst_valid", 32'(valid_o), 32'h0);
    checkOutput("rst_ready", 32'(ready_o), 32'h0);
    checkOutput("rst_data", 32'(data_o), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready_before_edge", 32'(ready_o), 32'h0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("ready_after_release", 32'(ready_o), 32'h1);
  endtask

  initial begin
    int cycles;
    rst       = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    data_i    = '0;
    exp_ready = 1'b0;
    last_data = '0;
    beats_in  = 0;
    beats_out = 0;
    #2;
    applyReset();

    // back-to-back streaming
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1);
      if (i == 1) checkOutput("stream_first", 32'(data_o), 32'h01);
    end
    checkOutput("stream_last", 32'(data_o), 32'h10);
    applyStimulus(1'b0, '0, 1'b1);

    // backpressure fills main then skid
    applyStimulus(1'b1, 8'hA1, 1'b0);
    applyStimulus(1'b1, 8'hA2, 1'b0);
    checkOutput("bp_full_ready", 32'(ready_o), 32'h0);
    checkOutput("bp_main", 32'(data_o), 32'hA1);
    applyStimulus(1'b1, 8'hA3, 1'b0);
    checkOutput("bp_held", 32'(data_o), 32'hA1);
    applyStimulus(1'b1, 8'hA3, 1'b1);
    checkOutput("bp_second", 32'(data_o), 32'hA2);
    applyStimulus(1'b1, 8'hA3, 1'b1);
    checkOutput("bp_third", 32'(data_o), 32'hA3);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("bp_empty_valid", 32'(valid_o), 32'h0);

    // stall stability
    applyStimulus(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'($urandom), 1'b0);
      checkOutput("stall_data", 32'(data_o), 32'h5A);
      checkOutput("stall_valid", 32'(valid_o), 32'h1);
    end
    applyStimulus(1'b0, '0, 1'b1);

    // drain from FULL
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkOutput("drain_head", 32'(data_o), 32'h11);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("drain_second", 32'(data_o), 32'h22);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("drain_valid", 32'(valid_o), 32'h0);
    checkOutput("drain_ready", 32'(ready_o), 32'h1);

    // reset while holding two beats
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    @(negedge clk);
    applyReset();

    // randomized traffic
    beats_in = 0;
    cycles   = 0;
    while (beats_in < RAND_BEATS && cycles < RAND_LIMIT) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      cycles++;
    end
    checkOutput("random_beats", 32'(beats_in), 32'(RAND_BEATS));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("random_drained", 32'(valid_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
